// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 2:1 TDM receive path.
// Optional parity support is selected with TDM_DEMUX_PARITY_EN.
package tdm_demux_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } state_t;

   localparam logic SLOT_A = 1'b0;
   localparam logic SLOT_B = 1'b1;

`ifdef TDM_DEMUX_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   // Frame length in link bits: two channels, each optionally carrying a parity bit.
   function automatic int frame_len(input int width, input bit parity);
      return parity ? 2 * (width + 1) : 2 * width;
   endfunction

endpackage

// File: rtl/tdm_slot_shifter.sv
// LSB-first shift register for one TDM channel; the first bit shifted in
// ends up in bit 0 after WIDTH shifts.
module tdm_slot_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             bit_in,
   output logic [WIDTH-1:0] word
);

   always_ff @(posedge clk) begin
      if (rst) begin
         word <= '0;
      end else if (clr && shift_en) begin
         word <= {bit_in, {(WIDTH-1){1'b0}}};
      end else if (clr) begin
         word <= '0;
      end else if (shift_en) begin
         word <= {bit_in, word[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/tdm_demux_1x2.sv
// Receive side of the 2:1 bit-interleaved link: locks on sof, splits A/B slots.
// Define TDM_DEMUX_PARITY_EN for trailing per-channel even-parity bits and par_err.
//
// state | meaning
// HUNT  | not framed; discard bits until a valid bit with sof
// RECV  | framed; cnt tracks the position of the next bit in the frame
module tdm_demux_1x2
   import tdm_demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             sof,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             out_valid,
   output logic             locked,
`ifdef TDM_DEMUX_PARITY_EN
   output logic             par_err,
`endif
   output logic             sync_err
);

   localparam int F  = frame_len(WIDTH, PARITY_EN);
   localparam int CW = $clog2(F);
   localparam logic [CW-1:0] LAST = CW'(F - 1);

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            shift_a, shift_b, clr;
   logic            frame_done, sync_err_nx;
   logic            data_slot;
   logic [WIDTH-1:0] a_word, b_word, b_last;

`ifdef TDM_DEMUX_PARITY_EN
   localparam logic [CW-1:0] PAR_A_IDX = CW'(2 * WIDTH);
   logic pa_bit, pa_ld, par_err_nx;

   assign data_slot  = (cnt < PAR_A_IDX);
   assign b_last     = b_word;
   assign par_err_nx = frame_done && ((pa_bit != ^a_word) || (din != ^b_word));

   always_ff @(posedge clk) begin
      if (rst) begin
         pa_bit  <= 1'b0;
         par_err <= 1'b0;
      end else begin
         if (pa_ld) pa_bit <= din;
         par_err <= par_err_nx;
      end
   end
`else
   assign data_slot = 1'b1;
   // Without parity the last frame bit is B's MSB, still in flight this cycle.
   assign b_last    = {din, b_word[WIDTH-1:1]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      shift_a     = 1'b0;
      shift_b     = 1'b0;
      clr         = 1'b0;
      frame_done  = 1'b0;
      sync_err_nx = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      pa_ld       = 1'b0;
`endif
      if (din_valid) begin
         case (state)
            HUNT: begin
               if (sof) begin
                  clr      = 1'b1;
                  shift_a  = 1'b1;
                  cnt_nx   = CW'(1);
                  state_nx = RECV;
               end
            end
            RECV: begin
               if (sof) begin
                  // sof mid-frame restarts framing on this bit
                  sync_err_nx = (cnt != '0);
                  clr         = 1'b1;
                  shift_a     = 1'b1;
                  cnt_nx      = CW'(1);
               end else if (cnt == '0) begin
                  sync_err_nx = 1'b1;
                  clr         = 1'b1;
                  state_nx    = HUNT;
               end else begin
                  if (data_slot) begin
                     shift_a = (cnt[0] == SLOT_A);
                     shift_b = (cnt[0] == SLOT_B);
                  end
`ifdef TDM_DEMUX_PARITY_EN
                  pa_ld = (cnt == PAR_A_IDX);
`endif
                  if (cnt == LAST) begin
                     frame_done = 1'b1;
                     cnt_nx     = '0;
                  end else begin
                     cnt_nx = cnt + CW'(1);
                  end
               end
            end
            default: state_nx = HUNT;
         endcase
      end
   end

   tdm_slot_shifter #(.WIDTH(WIDTH)) u_shift_a (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .shift_en (shift_a),
      .bit_in   (din),
      .word     (a_word)
   );

   tdm_slot_shifter #(.WIDTH(WIDTH)) u_shift_b (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .shift_en (shift_b),
      .bit_in   (din),
      .word     (b_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         a_out     <= '0;
         b_out     <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         out_valid <= frame_done;
         sync_err  <= sync_err_nx;
         if (frame_done) begin
            a_out <= a_word;
            b_out <= b_last;
         end
      end
   end

   assign locked = (state == RECV);

endmodule

// File: tb/tb_tdm_demux_1x2.sv
// Directed bench for tdm_demux_1x2; parity cases build when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux_1x2;

   localparam int WIDTH = 8;
`ifdef TDM_DEMUX_PARITY_EN
   localparam int F = 2 * (WIDTH + 1);
`else
   localparam int F = 2 * WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst, din, din_valid, sof;
   logic [WIDTH-1:0] a_out, b_out;
   logic             out_valid, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
   logic             par_err;
`endif

   tdm_demux_1x2 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .sof       (sof),
      .a_out     (a_out),
      .b_out     (b_out),
      .out_valid (out_valid),
      .locked    (locked),
`ifdef TDM_DEMUX_PARITY_EN
      .par_err   (par_err),
`endif
      .sync_err  (sync_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int edge_cnt = 0;
   int ov_cnt, se_cnt, hold_viol;
   int ov_edge[$];
   logic [WIDTH-1:0] ov_a[$], ov_b[$];
   logic ov_pe[$];
   logic [WIDTH-1:0] prev_a = '0, prev_b = '0;
   int sof_edge, sof_edge0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, take the edge, then observe 1ns later.
   task automatic step(input logic v, input logic s, input logic b);
      din_valid = v;
      sof       = s;
      din       = b;
      @(posedge clk);
      edge_cnt++;
      #1;
      if (out_valid) begin
         ov_cnt++;
         ov_edge.push_back(edge_cnt);
         ov_a.push_back(a_out);
         ov_b.push_back(b_out);
`ifdef TDM_DEMUX_PARITY_EN
         ov_pe.push_back(par_err);
`else
         ov_pe.push_back(1'b0);
`endif
      end
      if (sync_err) se_cnt++;
      if (!out_valid && !rst && (a_out !== prev_a || b_out !== prev_b)) hold_viol++;
      prev_a = a_out;
      prev_b = b_out;
   endtask

   task automatic clear_log();
      ov_cnt = 0;
      se_cnt = 0;
      ov_edge.delete();
      ov_a.delete();
      ov_b.delete();
      ov_pe.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      clear_log();
   endtask

   function automatic logic frame_bit(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input int k, input logic pa, input logic pb);
      if (k < 2 * WIDTH) return (k % 2 == 0) ? a[k/2] : b[k/2];
      return (k == 2 * WIDTH) ? pa : pb;
   endfunction

   // Sends bits 0..nbits-1 of a frame; with gap, an idle cycle precedes every bit but the first.
   task automatic send_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input bit gap, input bit pa_bad, input int nbits);
      logic pa, pb;
      pa = (^a) ^ pa_bad;
      pb = ^b;
      for (int k = 0; k < nbits; k++) begin
         if (gap && k > 0) step(1'b0, 1'b0, 1'b1);
         step(1'b1, (k == 0), frame_bit(a, b, k, pa, pb));
         if (k == 0) sof_edge = edge_cnt;
      end
   endtask

   // Edge on which a downstream register would capture the i-th logged out_valid.
   function automatic int ov_lat(input int i, input int from_edge);
      return ov_edge[i] + 1 - from_edge;
   endfunction

   initial begin
      rst = 1'b1; din = 1'b0; din_valid = 1'b0; sof = 1'b0;
      ov_cnt = 0; se_cnt = 0; hold_viol = 0;
      do_reset();
      check_val("rst_a_out", a_out, 0);
      check_val("rst_b_out", b_out, 0);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_locked", locked, 0);
      check_val("rst_sync_err", sync_err, 0);

      // Continuous frame A5/3C
      send_frame(8'hA5, 8'h3C, 1'b0, 1'b0, F);
      step(1'b0, 1'b0, 1'b0);
      check_val("t1_ov_cnt", ov_cnt, 1);
      if (ov_cnt == 1) begin
         check_val("t1_latency", ov_lat(0, sof_edge), F);
         check_val("t1_a", ov_a[0], 8'hA5);
         check_val("t1_b", ov_b[0], 8'h3C);
         check_val("t1_par_err", ov_pe[0], 0);
      end
      check_val("t1_locked", locked, 1);
      check_val("t1_sync_err", se_cnt, 0);

      // Same frame with an idle cycle between bits (F-1 gaps)
      do_reset();
      hold_viol = 0;
      send_frame(8'hA5, 8'h3C, 1'b1, 1'b0, F);
      step(1'b0, 1'b0, 1'b0);
      check_val("t2_ov_cnt", ov_cnt, 1);
      if (ov_cnt == 1) begin
         check_val("t2_latency", ov_lat(0, sof_edge), 2 * F - 1);
         check_val("t2_a", ov_a[0], 8'hA5);
         check_val("t2_b", ov_b[0], 8'h3C);
      end
      check_val("t2_hold", hold_viol, 0);

      // Back-to-back frames
      do_reset();
      send_frame(8'hA5, 8'h3C, 1'b0, 1'b0, F);
      sof_edge0 = sof_edge;
      send_frame(8'h5A, 8'hC3, 1'b0, 1'b0, F);
      step(1'b0, 1'b0, 1'b0);
      check_val("t3_ov_cnt", ov_cnt, 2);
      if (ov_cnt == 2) begin
         check_val("t3_lat0", ov_lat(0, sof_edge0), F);
         check_val("t3_lat1", ov_lat(1, sof_edge0), 2 * F);
         check_val("t3_a0", ov_a[0], 8'hA5);
         check_val("t3_b0", ov_b[0], 8'h3C);
         check_val("t3_a1", ov_a[1], 8'h5A);
         check_val("t3_b1", ov_b[1], 8'hC3);
      end
      check_val("t3_sync_err", se_cnt, 0);

      // sof reasserted at frame bit 7, then full frame 0F/F0
      clear_log();
      send_frame(8'hA5, 8'h3C, 1'b0, 1'b0, 7);
      send_frame(8'h0F, 8'hF0, 1'b0, 1'b0, F);
      step(1'b0, 1'b0, 1'b0);
      check_val("t4_sync_err", se_cnt, 1);
      check_val("t4_ov_cnt", ov_cnt, 1);
      check_val("t4_a", a_out, 8'h0F);
      check_val("t4_b", b_out, 8'hF0);

      // Bit after a completed frame without sof: lose lock, ignore until sof
      clear_log();
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check_val("t5_sync_err", se_cnt, 1);
      check_val("t5_locked", locked, 0);
      for (int i = 0; i < 2 * F; i++) step(1'b1, 1'b0, i[0]);
      check_val("t5_hunt_ov", ov_cnt, 0);
      check_val("t5_hunt_se", se_cnt, 1);
      check_val("t5_hunt_locked", locked, 0);
      check_val("t5_hold_a", a_out, 8'h0F);
      send_frame(8'h5A, 8'hC3, 1'b0, 1'b0, F);
      step(1'b0, 1'b0, 1'b0);
      check_val("t5_relock_ov", ov_cnt, 1);
      check_val("t5_relock_a", a_out, 8'h5A);
      check_val("t5_relock_b", b_out, 8'hC3);

`ifdef TDM_DEMUX_PARITY_EN
      // Wrong A parity: words still delivered, par_err with out_valid
      do_reset();
      send_frame(8'h01, 8'h00, 1'b0, 1'b1, F);
      step(1'b0, 1'b0, 1'b0);
      check_val("p_ov_cnt", ov_cnt, 1);
      if (ov_cnt == 1) begin
         check_val("p_a", ov_a[0], 8'h01);
         check_val("p_b", ov_b[0], 8'h00);
         check_val("p_par_err", ov_pe[0], 1);
      end
`endif

      // Reset mid-frame: outputs to 0, no delivery of the partial frame
      clear_log();
      send_frame(8'hFF, 8'hFF, 1'b0, 1'b0, 5);
      rst = 1'b1;
      step(1'b1, 1'b0, 1'b1);
      rst = 1'b0;
      check_val("mr_a", a_out, 0);
      check_val("mr_b", b_out, 0);
      check_val("mr_out_valid", out_valid, 0);
      check_val("mr_locked", locked, 0);
      check_val("mr_sync_err", sync_err, 0);
`ifdef TDM_DEMUX_PARITY_EN
      check_val("mr_par_err", par_err, 0);
`endif
      for (int i = 0; i < F; i++) step(1'b1, 1'b0, 1'b1);
      check_val("mr_no_ov", ov_cnt, 0);
      check_val("all_hold", hold_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
